// File: rtl/ps2_host_ctrl.sv
// Host-side PS/2 port controller: sends command frames, checks for 0xFA/0xFE replies, and forwards key bytes.
// Latency: a key byte appears on key_valid 1 cycle after the rx_done edge. Commands are accepted only in IDLE, so cmd_ready low is the backpressure.
// Optional power-on 0xFF/BAT sequence is compiled in when PS2_HOST_CTRL_BAT_EN is defined.
module ps2_host_ctrl #(
   parameter int INHIBIT_CYC = 5000,
   parameter int TIMEOUT_CYC = 1000000,
   parameter int MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   output logic       cmd_ok,
   output logic       cmd_err,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   output logic       rx_reset,
   output logic [7:0] key_data,
   output logic       key_valid,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_drv,
   output logic       ps2_data_drv
);

   localparam int TMR_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

`ifdef PS2_HOST_CTRL_BAT_EN
   localparam logic BAT_EN = 1'b1;
`else
   localparam logic BAT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_RTS, S_TXBITS, S_LINEACK, S_WAITACK, S_RETRY, S_BATAA
   } state_t;

   localparam state_t     RST_STATE = BAT_EN ? S_INHIBIT : S_IDLE;
   localparam logic [7:0] RST_CMD   = BAT_EN ? 8'hFF : 8'h00;
   localparam logic [9:0] RST_SHIFT = BAT_EN ? {1'b1, 1'b1, 8'hFF} : 10'h000;

   state_t             state_q, state_d;
   logic               clk_s1, clk_s2, data_s1, data_s2;
   logic [7:0]         filt_sr;
   logic               clk_filt, fall_q;
   logic               rx_done_q, rx_edge;
   logic [TMR_W-1:0]   timer_q;
   logic               timed_out, inhibit_done;
   logic [7:0]         cmd_byte;
   logic [9:0]         shift_q;
   logic [3:0]         bit_cnt;
   logic [RTY_W-1:0]   retry_q;
   logic               bat_q;

   logic clk_drv_d, data_drv_d, rx_reset_d;
   logic ok_d, err_d, fwd, accept, load_retry, tx_shift, bat_clr;

   assign cmd_ready    = (state_q == S_IDLE);
   assign rx_edge      = rx_done & ~rx_done_q & ~rx_reset;
   assign timed_out    = (timer_q == TMR_W'(TIMEOUT_CYC - 1));
   assign inhibit_done = (timer_q == TMR_W'(INHIBIT_CYC - 1));

   // Line synchronisers; clock is deglitched by requiring 8 identical samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_s1    <= 1'b1;
         clk_s2    <= 1'b1;
         data_s1   <= 1'b1;
         data_s2   <= 1'b1;
         filt_sr   <= 8'hFF;
         clk_filt  <= 1'b1;
         fall_q    <= 1'b0;
         rx_done_q <= 1'b0;
      end else begin
         clk_s1    <= ps2_clk_in;
         clk_s2    <= clk_s1;
         data_s1   <= ps2_data_in;
         data_s2   <= data_s1;
         filt_sr   <= {filt_sr[6:0], clk_s2};
         if (filt_sr == 8'h00)
            clk_filt <= 1'b0;
         else if (filt_sr == 8'hFF)
            clk_filt <= 1'b1;
         fall_q    <= clk_filt & (filt_sr == 8'h00);
         rx_done_q <= rx_done;
      end
   end

   // Our own inhibit pulls the clock low, so that edge must not restart the inhibit count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         timer_q <= '0;
      else if ((state_d != state_q) || (state_q == S_IDLE) ||
               (fall_q && (state_q != S_INHIBIT)))
         timer_q <= '0;
      else
         timer_q <= timer_q + TMR_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= RST_STATE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      clk_drv_d  = ps2_clk_drv;
      data_drv_d = ps2_data_drv;
      rx_reset_d = rx_reset;
      ok_d       = 1'b0;
      err_d      = 1'b0;
      fwd        = 1'b0;
      accept     = 1'b0;
      load_retry = 1'b0;
      tx_shift   = 1'b0;
      bat_clr    = 1'b0;
      case (state_q)
         S_IDLE: begin
            clk_drv_d  = 1'b0;
            data_drv_d = 1'b0;
            rx_reset_d = 1'b0;
            fwd        = rx_edge;
            if (cmd_valid) begin
               accept     = 1'b1;
               state_d    = S_INHIBIT;
               clk_drv_d  = 1'b1;
               rx_reset_d = 1'b1;
            end
         end
         S_INHIBIT: begin
            clk_drv_d  = 1'b1;
            data_drv_d = 1'b0;
            rx_reset_d = 1'b1;
            if (inhibit_done) begin
               state_d    = S_RTS;
               clk_drv_d  = 1'b0;
               data_drv_d = 1'b1;
            end
         end
         S_RTS: begin
            state_d = S_TXBITS;
         end
         S_TXBITS: begin
            if (fall_q) begin
               tx_shift   = 1'b1;
               data_drv_d = ~shift_q[0];
               if (bit_cnt == 4'd9)
                  state_d = S_LINEACK;
            end else if (timed_out) begin
               clk_drv_d  = 1'b0;
               data_drv_d = 1'b0;
               state_d    = S_RETRY;
            end
         end
         S_LINEACK: begin
            if (fall_q) begin
               if (!data_s2) begin
                  state_d    = S_WAITACK;
                  rx_reset_d = 1'b0;
               end else begin
                  state_d = S_RETRY;
               end
            end else if (timed_out) begin
               clk_drv_d  = 1'b0;
               data_drv_d = 1'b0;
               state_d    = S_RETRY;
            end
         end
         S_WAITACK: begin
            if (rx_edge) begin
               if (rx_data == 8'hFA) begin
                  clk_drv_d  = 1'b0;
                  data_drv_d = 1'b0;
                  rx_reset_d = 1'b0;
                  if (bat_q) begin
                     state_d = S_BATAA;
                  end else begin
                     ok_d    = 1'b1;
                     state_d = S_IDLE;
                  end
               end else if (rx_data == 8'hFE) begin
                  state_d = S_RETRY;
               end else begin
                  fwd = 1'b1;
               end
            end else if (timed_out) begin
               clk_drv_d  = 1'b0;
               data_drv_d = 1'b0;
               state_d    = S_RETRY;
            end
         end
         S_RETRY: begin
            if (retry_q < RTY_W'(MAX_RETRY)) begin
               load_retry = 1'b1;
               state_d    = S_INHIBIT;
               clk_drv_d  = 1'b1;
               data_drv_d = 1'b0;
               rx_reset_d = 1'b1;
            end else begin
               err_d      = 1'b1;
               bat_clr    = 1'b1;
               state_d    = S_IDLE;
               clk_drv_d  = 1'b0;
               data_drv_d = 1'b0;
               rx_reset_d = 1'b0;
            end
         end
         S_BATAA: begin
            // Anything other than a timely 0xAA counts as a failed self-test.
            if (rx_edge || timed_out) begin
               err_d   = ~(rx_edge && (rx_data == 8'hAA));
               bat_clr = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ps2_clk_drv  <= 1'b0;
         ps2_data_drv <= 1'b0;
         rx_reset     <= 1'b0;
         cmd_ok       <= 1'b0;
         cmd_err      <= 1'b0;
         key_valid    <= 1'b0;
         key_data     <= 8'h00;
         cmd_byte     <= RST_CMD;
         shift_q      <= RST_SHIFT;
         bit_cnt      <= 4'd0;
         retry_q      <= '0;
         bat_q        <= BAT_EN;
      end else begin
         ps2_clk_drv  <= clk_drv_d;
         ps2_data_drv <= data_drv_d;
         rx_reset     <= rx_reset_d;
         cmd_ok       <= ok_d;
         cmd_err      <= err_d;
         key_valid    <= fwd;
         if (fwd)
            key_data <= rx_data;
         if (bat_clr)
            bat_q <= 1'b0;
         if (accept) begin
            cmd_byte <= cmd_data;
            shift_q  <= {1'b1, ~^cmd_data, cmd_data};
            retry_q  <= '0;
            bit_cnt  <= 4'd0;
         end else if (load_retry) begin
            shift_q  <= {1'b1, ~^cmd_byte, cmd_byte};
            retry_q  <= retry_q + RTY_W'(1);
            bit_cnt  <= 4'd0;
         end else if (tx_shift) begin
            shift_q  <= {1'b0, shift_q[9:1]};
            bit_cnt  <= bit_cnt + 4'd1;
         end else if (state_q == S_RTS) begin
            bit_cnt  <= 4'd0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: PS/2 device model on the open-drain lines plus a stand-in for the ps2_rx receiver.
// A table of scripted device behaviours is followed by randomized commands that are checked against an outcome model.
module tb_ps2_host_ctrl;
   localparam int INH  = 50;
   localparam int TMO  = 600;
   localparam int MR   = 3;
   localparam int HALF = 20;

   // Device behaviour per frame: 0 ack FA, 1 reply FE, 2 line-ack missing, 3 silent, 4 key then FA, 5 stop after 4 edges
   typedef struct {
      logic [7:0]       cmd;
      logic [3:0][2:0]  beh;
      int               rts;
      int               frames;
      bit               ok;
      int               keys;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ready, cmd_ok, cmd_err, rx_reset, key_valid;
   logic [7:0] rx_data, key_data;
   logic       rx_done;
   logic       ps2_clk_in, ps2_data_in, clk_drv, data_drv;
   logic       dev_clk_low, dev_data_low;

   int total = 0;
   int bad = 0;
   int ok_cnt = 0;
   int err_cnt = 0;
   int rts_cnt = 0;
   int rts_rxrst = 0;
   int dev_edges = 0;
   logic [7:0] keys_q[$];
   logic [9:0] frames_q[$];
   int         beh_q[$];
   logic [7:0] key_req_q[$];

   always #5 clk = ~clk;

   assign ps2_clk_in  = ~(clk_drv | dev_clk_low);
   assign ps2_data_in = ~(data_drv | dev_data_low);

   ps2_host_ctrl #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .MAX_RETRY(MR)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
      .cmd_ok(cmd_ok), .cmd_err(cmd_err),
      .rx_data(rx_data), .rx_done(rx_done), .rx_reset(rx_reset),
      .key_data(key_data), .key_valid(key_valid),
      .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .ps2_clk_drv(clk_drv), .ps2_data_drv(data_drv)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmd_ok)    ok_cnt++;
      if (cmd_err)   err_cnt++;
      if (key_valid) keys_q.push_back(key_data);
   end

   task automatic send_byte(input logic [7:0] v);
      rx_data = v;
      rx_done = 1'b1;
      repeat (4) @(negedge clk);
      rx_done = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // Device model: answers each request-to-send according to the next queued behaviour.
   initial begin : device
      int b;
      logic [9:0] frm;
      dev_clk_low = 1'b0; dev_data_low = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
      forever begin
         @(negedge clk);
         if (key_req_q.size() > 0) begin
            send_byte(key_req_q.pop_front());
         end else if (!reset && data_drv && !clk_drv) begin
            b = (beh_q.size() > 0) ? beh_q.pop_front() : 0;
            rts_cnt++;
            if (rx_reset) rts_rxrst++;
            if (b == 3) begin
               while (data_drv) @(negedge clk);
            end else begin
               frm = '0;
               repeat (HALF) @(negedge clk);
               for (int i = 0; i < 11; i++) begin
                  if (b == 5 && i == 4) break;
                  dev_clk_low = 1'b1;
                  dev_edges++;
                  repeat (HALF) @(negedge clk);
                  dev_clk_low = 1'b0;
                  repeat (HALF) @(negedge clk);
                  if (i < 10) frm[i] = ps2_data_in;
                  if (i == 9 && b != 2) dev_data_low = 1'b1;
               end
               dev_data_low = 1'b0;
               if (b == 5) begin
                  while (data_drv) @(negedge clk);
               end else begin
                  frames_q.push_back(frm);
                  repeat (30) @(negedge clk);
                  if (b == 4) begin
                     send_byte(8'h55);
                     send_byte(8'hFA);
                  end else if (b == 0) begin
                     send_byte(8'hFA);
                  end else if (b == 1) begin
                     send_byte(8'hFE);
                  end
               end
            end
         end
      end
   end

   function automatic vec_t mk(input logic [7:0] c, input int a0, input int a1, input int a2,
                               input int a3, input int rts, input int fr, input bit ok, input int keys);
      vec_t v;
      v.cmd = c;
      v.beh[0] = 3'(a0); v.beh[1] = 3'(a1); v.beh[2] = 3'(a2); v.beh[3] = 3'(a3);
      v.rts = rts; v.frames = fr; v.ok = ok; v.keys = keys;
      return v;
   endfunction

   // Outcome model: attempts run until one is acknowledged or 1+MR attempts are spent.
   task automatic predict(input logic [3:0][2:0] beh, output int rts, output int fr,
                          output bit ok, output int keys);
      ok = 0; rts = 0; fr = 0; keys = 0;
      for (int i = 0; i < 1 + MR; i++) begin
         if (!ok) begin
            rts++;
            if (beh[i] != 3'd3) fr++;
            if (beh[i] == 3'd4) keys++;
            if (beh[i] == 3'd0 || beh[i] == 3'd4) ok = 1;
         end
      end
   endtask

   task automatic idle_key(input string tag, input logic [7:0] v);
      int k0;
      bit rdy_drop;
      k0 = keys_q.size();
      rdy_drop = 0;
      key_req_q.push_back(v);
      repeat (20) begin
         @(negedge clk);
         if (!cmd_ready) rdy_drop = 1;
      end
      chk({tag, "_key_count"}, keys_q.size() - k0, 1);
      if (keys_q.size() > k0) chk({tag, "_key_data"}, keys_q[k0], v);
      chk({tag, "_ready_held"}, rdy_drop, 0);
   endtask

   task automatic run_cmd(input string tag, input vec_t v);
      int ok0, err0, k0, f0, r0, rr0;
      bit done;
      beh_q.delete();
      for (int i = 0; i < 4; i++) beh_q.push_back(int'(v.beh[i]));
      ok0 = ok_cnt; err0 = err_cnt; k0 = keys_q.size(); f0 = frames_q.size();
      r0 = rts_cnt; rr0 = rts_rxrst;
      @(negedge clk);
      cmd_data  = v.cmd;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk({tag, "_ready_busy"}, cmd_ready, 0);
      done = 0;
      for (int n = 0; n < 8000; n++) begin
         @(negedge clk);
         if (ok_cnt != ok0 || err_cnt != err0) begin
            done = 1;
            break;
         end
      end
      chk({tag, "_completed"}, done, 1);
      repeat (60) @(negedge clk);
      chk({tag, "_rts"}, rts_cnt - r0, v.rts);
      chk({tag, "_rxrst_tx"}, rts_rxrst - rr0, rts_cnt - r0);
      chk({tag, "_frames"}, frames_q.size() - f0, v.frames);
      chk({tag, "_ok"}, ok_cnt - ok0, v.ok);
      chk({tag, "_err"}, err_cnt - err0, !v.ok);
      chk({tag, "_keys"}, keys_q.size() - k0, v.keys);
      for (int j = f0; j < frames_q.size(); j++) begin
         chk({tag, "_byte"}, frames_q[j][7:0], v.cmd);
         chk({tag, "_parity"}, frames_q[j][8], ~^v.cmd);
         chk({tag, "_stop"}, frames_q[j][9], 1'b1);
      end
      for (int j = k0; j < keys_q.size(); j++) chk({tag, "_fwd_key"}, keys_q[j], 8'h55);
      chk({tag, "_released"}, {clk_drv, data_drv, rx_reset}, 3'b000);
      chk({tag, "_ready_back"}, cmd_ready, 1);
      beh_q.delete();
   endtask

   initial begin : watchdog
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t tbl[7];
      vec_t rv;
      int ok0, err0, k0, e0;
      bit found;
      logic [3:0][2:0] rb;
      int p_rts, p_fr, p_keys;
      bit p_ok;

      tbl[0] = mk(8'hED, 0, 0, 0, 0, 1, 1, 1'b1, 0);
      tbl[1] = mk(8'hF4, 1, 1, 1, 0, 4, 4, 1'b1, 0);
      tbl[2] = mk(8'hF3, 3, 3, 3, 3, 4, 0, 1'b0, 0);
      tbl[3] = mk(8'hF2, 2, 2, 2, 2, 4, 4, 1'b0, 0);
      tbl[4] = mk(8'hEE, 4, 0, 0, 0, 1, 1, 1'b1, 1);
      tbl[5] = mk(8'h20, 1, 2, 3, 4, 4, 3, 1'b1, 1);
      tbl[6] = mk(8'h5A, 3, 0, 0, 0, 2, 1, 1'b1, 0);

      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_cmd_ok", cmd_ok, 0);
      chk("rst_cmd_err", cmd_err, 0);
      chk("rst_key_valid", key_valid, 0);
      chk("rst_key_data", key_data, 8'h00);
      chk("rst_rx_reset", rx_reset, 0);
      chk("rst_drv", {clk_drv, data_drv}, 2'b00);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      idle_key("idle_1c", 8'h1C);

      for (int i = 0; i < 7; i++) run_cmd($sformatf("tbl%0d", i), tbl[i]);

      idle_key("late_fa", 8'hFA);

      // Reset in the middle of a frame, while data bit 4 is on the line.
      beh_q.delete();
      beh_q.push_back(5);
      ok0 = ok_cnt; err0 = err_cnt; k0 = keys_q.size(); e0 = dev_edges;
      @(negedge clk);
      cmd_data = 8'h00; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      found = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (dev_edges >= e0 + 4) begin
            found = 1;
            break;
         end
      end
      chk("midrst_reach_bit4", found, 1);
      repeat (16) @(negedge clk);
      chk("midrst_data_driven", data_drv, 1);
      reset = 1'b1;
      #1;
      chk("midrst_drv_released", {clk_drv, data_drv}, 2'b00);
      chk("midrst_ready", cmd_ready, 1);
      chk("midrst_rx_reset", rx_reset, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      chk("midrst_no_ok", ok_cnt - ok0, 0);
      chk("midrst_no_err", err_cnt - err0, 0);
      chk("midrst_no_key", keys_q.size() - k0, 0);
      beh_q.delete();

      for (int r = 0; r < 8; r++) begin
         idle_key($sformatf("rnd_key%0d", r), 8'($urandom));
         for (int i = 0; i < 4; i++) rb[i] = 3'($urandom_range(0, 4));
         predict(rb, p_rts, p_fr, p_ok, p_keys);
         rv = mk(8'($urandom), int'(rb[0]), int'(rb[1]), int'(rb[2]), int'(rb[3]),
                 p_rts, p_fr, p_ok, p_keys);
         run_cmd($sformatf("rnd%0d", r), rv);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
